control_contador: RTL and testbench

- Command-driven sequencer for the 16-bit cascaded counter (4 x 4-bit stages, one RCO bit per stage).
- Accepts one command at a time over a valid/ready handshake and drives the counter's enb, modo and D.
- Counts top-stage wrap events on RCO and reports completion with the captured final Q.
- Sits between the test/control logic and the counter; replaces hand-timed enb/modo stimulus.

---
 rtl/contador_pkg.sv | 22 ++
 rtl/control_contador_if.sv | 29 ++
 rtl/contador_ciclos.sv | 28 ++
 rtl/control_contador.sv | 140 ++++++++++++++
 tb/tb_control_contador.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/contador_pkg.sv
// Shared constants for the cascaded-counter sequencer: counter modes, FSM encoding, default widths.
package contador_pkg;

  localparam int ANCHO_DEF         = 16;
  localparam int ANCHO_CICLOS_DEF  = 16;
  localparam int ANCHO_VUELTAS_DEF = 8;

  localparam logic [1:0] MODO_ASC   = 2'b00;
  localparam logic [1:0] MODO_DESC  = 2'b01;
  localparam logic [1:0] MODO_TRES  = 2'b10;
  localparam logic [1:0] MODO_CARGA = 2'b11;

  localparam logic [1:0] ST_INICIO = 2'd0;
  localparam logic [1:0] ST_CARGA  = 2'd1;
  localparam logic [1:0] ST_CUENTA = 2'd2;
  localparam logic [1:0] ST_FIN    = 2'd3;

  function automatic logic es_carga(input logic [1:0] modo);
    return modo == MODO_CARGA;
  endfunction

endpackage

// File: rtl/control_contador_if.sv
// Command/completion bus between the test/control logic (master) and control_contador (slave).
interface control_contador_if #(
  parameter int ANCHO         = contador_pkg::ANCHO_DEF,
  parameter int ANCHO_CICLOS  = contador_pkg::ANCHO_CICLOS_DEF,
  parameter int ANCHO_VUELTAS = contador_pkg::ANCHO_VUELTAS_DEF
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_modo;
  logic [ANCHO-1:0]         cmd_dato;
  logic [ANCHO_CICLOS-1:0]  cmd_ciclos;
  logic                     parar;
  logic                     hecho;
  logic                     abortado;
  logic [ANCHO-1:0]         q_final;
  logic [ANCHO_VUELTAS-1:0] vueltas;

  modport master (
    output cmd_valid, cmd_modo, cmd_dato, cmd_ciclos, parar,
    input  cmd_ready, hecho, abortado, q_final, vueltas
  );

  modport slave (
    input  cmd_valid, cmd_modo, cmd_dato, cmd_ciclos, parar,
    output cmd_ready, hecho, abortado, q_final, vueltas
  );

endinterface

// File: rtl/contador_ciclos.sv
// Loadable down-counter of remaining CUENTA cycles; o_ultimo flags the final enabled cycle.
module contador_ciclos #(
  parameter int ANCHO_CICLOS = contador_pkg::ANCHO_CICLOS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_cargar,
  input  logic [ANCHO_CICLOS-1:0] i_valor,
  input  logic                    i_decr,
  output logic                    o_ultimo
);

  logic [ANCHO_CICLOS-1:0] r_restante;

  // NOTE: state registers use non-blocking assignments and an async reset in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_restante <= '0;
    end else if (i_cargar) begin
      r_restante <= i_valor;
    end else if (i_decr && (r_restante != '0)) begin
      r_restante <= r_restante - 1'b1;
    end
  end

  assign o_ultimo = (r_restante == ANCHO_CICLOS'(1));

endmodule

// File: rtl/control_contador.sv
// Command sequencer for the 16-bit cascaded counter; drives enb/modo/D and reports completion.
// Define PRECARGA_EN to preload cmd_dato (one CARGA cycle) before every count command.
module control_contador
  import contador_pkg::*;
#(
  parameter int ANCHO         = ANCHO_DEF,
  parameter int ANCHO_CICLOS  = ANCHO_CICLOS_DEF,
  parameter int ANCHO_VUELTAS = ANCHO_VUELTAS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  control_contador_if.slave bus,
  output logic             enb,
  output logic [1:0]       modo,
  output logic [ANCHO-1:0] D,
  input  logic [ANCHO-1:0] Q,
  input  logic [3:0]       RCO
);

`ifdef PRECARGA_EN
  localparam bit PRECARGA = 1'b1;
`else
  localparam bit PRECARGA = 1'b0;
`endif

  logic [1:0]               r_estado;
  logic [1:0]               r_modo_cmd;
  logic                     r_ciclos_cero;
  logic                     r_abort_pend;
  logic                     r_enb;
  logic [1:0]               r_modo;
  logic [ANCHO-1:0]         r_D;
  logic                     r_hecho;
  logic                     r_abortado;
  logic [ANCHO-1:0]         r_q_final;
  logic [ANCHO_VUELTAS-1:0] r_vueltas;

  logic w_ready;
  logic w_acepta;
  logic w_ciclos_cero;
  logic w_pasa_carga;
  logic w_ultimo;
  logic w_unused_rco;

  assign w_ready       = (r_estado == ST_INICIO);
  assign w_acepta      = bus.cmd_valid && w_ready;
  assign w_ciclos_cero = (bus.cmd_ciclos == '0);
  assign w_pasa_carga  = es_carga(bus.cmd_modo) || PRECARGA;
  // Only the top-stage wrap is counted; lower-stage carries are observed by the counter itself.
  assign w_unused_rco  = ^RCO[2:0];

  contador_ciclos #(.ANCHO_CICLOS(ANCHO_CICLOS)) u_ciclos (
    .clk      (clk),
    .reset    (reset),
    .i_cargar (w_acepta),
    .i_valor  (bus.cmd_ciclos),
    .i_decr   (r_estado == ST_CUENTA),
    .o_ultimo (w_ultimo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado      <= ST_INICIO;
      r_modo_cmd    <= MODO_ASC;
      r_ciclos_cero <= 1'b0;
      r_abort_pend  <= 1'b0;
      r_enb         <= 1'b0;
      r_modo        <= MODO_ASC;
      r_D           <= '0;
      r_hecho       <= 1'b0;
      r_abortado    <= 1'b0;
      r_q_final     <= '0;
      r_vueltas     <= '0;
    end else begin
      r_hecho    <= 1'b0;
      r_abortado <= 1'b0;
      case (r_estado)
        ST_INICIO: begin
          if (w_acepta) begin
            r_modo_cmd    <= bus.cmd_modo;
            r_ciclos_cero <= w_ciclos_cero;
            r_abort_pend  <= 1'b0;
            r_vueltas     <= '0;
            if (w_pasa_carga) begin
              r_estado <= ST_CARGA;
              r_enb    <= 1'b1;
              r_modo   <= MODO_CARGA;
              r_D      <= bus.cmd_dato;
            end else if (w_ciclos_cero) begin
              r_estado <= ST_FIN;
            end else begin
              r_estado <= ST_CUENTA;
              r_enb    <= 1'b1;
              r_modo   <= bus.cmd_modo;
            end
          end
        end
        ST_CARGA: begin
          // A preload that precedes a non-empty count hands straight over to CUENTA.
          if (es_carga(r_modo_cmd) || r_ciclos_cero) begin
            r_estado <= ST_FIN;
            r_enb    <= 1'b0;
          end else begin
            r_estado <= ST_CUENTA;
            r_modo   <= r_modo_cmd;
          end
        end
        ST_CUENTA: begin
          if (RCO[3] && (r_vueltas != {ANCHO_VUELTAS{1'b1}})) begin
            r_vueltas <= r_vueltas + 1'b1;
          end
          if (w_ultimo) begin
            r_estado <= ST_FIN;
            r_enb    <= 1'b0;
          end else if (bus.parar) begin
            r_estado     <= ST_FIN;
            r_enb        <= 1'b0;
            r_abort_pend <= 1'b1;
          end
        end
        default: begin
          r_estado   <= ST_INICIO;
          r_hecho    <= 1'b1;
          r_abortado <= r_abort_pend;
          r_q_final  <= Q;
        end
      endcase
    end
  end

  assign enb           = r_enb;
  assign modo          = r_modo;
  assign D             = r_D;
  assign bus.cmd_ready = w_ready;
  assign bus.hecho     = r_hecho;
  assign bus.abortado  = r_abortado;
  assign bus.q_final   = r_q_final;
  assign bus.vueltas   = r_vueltas;

endmodule

// File: tb/tb_control_contador.sv
// Self-checking bench: behavioural counter plus a per-command reference model of latency, enb, Q and wraps.
module tb_control_contador;
  import contador_pkg::*;

  localparam int ANCHO = 16;
  localparam int AC    = 16;
  localparam int AV    = 8;
`ifdef PRECARGA_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enb;
  logic [1:0]       modo;
  logic [ANCHO-1:0] D;
  logic [ANCHO-1:0] q_cnt;
  logic [3:0]       rco;
  logic             rco_force;
  logic [15:0]      ref_q;

  int n_checks = 0;
  int n_fail   = 0;

  control_contador_if #(.ANCHO(ANCHO), .ANCHO_CICLOS(AC), .ANCHO_VUELTAS(AV)) bus ();

  control_contador #(.ANCHO(ANCHO), .ANCHO_CICLOS(AC), .ANCHO_VUELTAS(AV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .enb   (enb),
    .modo  (modo),
    .D     (D),
    .Q     (q_cnt),
    .RCO   (rco)
  );

  always #5 clk = ~clk;

  // Behavioural 4 x 4-bit cascaded counter that the sequencer drives.
  always @(posedge clk or posedge reset) begin
    if (reset) q_cnt <= '0;
    else if (enb) begin
      case (modo)
        MODO_ASC:  q_cnt <= q_cnt + 16'd1;
        MODO_DESC: q_cnt <= q_cnt - 16'd1;
        MODO_TRES: q_cnt <= q_cnt + 16'd3;
        default:   q_cnt <= D;
      endcase
    end
  end

  function automatic int unsigned mascara(input int etapa);
    return (32'd1 << (4 * etapa + 4)) - 32'd1;
  endfunction

  always_comb begin
    rco = '0;
    if (rco_force) rco[3] = 1'b1;
    else if (enb && (modo != MODO_CARGA)) begin
      for (int i = 0; i < 4; i++) begin
        if (modo == MODO_DESC) rco[i] = ((32'(q_cnt) & mascara(i)) == 0);
        else rco[i] = ((32'(q_cnt) & mascara(i)) + ((modo == MODO_TRES) ? 32'd3 : 32'd1)) > mascara(i);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready", bus.cmd_ready, 1);
  endtask

  // parar_at > 0: raise parar in that count cycle; parar_at < 0: raise parar in every non-count cycle.
  task automatic run_cmd(input logic [1:0] m, input logic [15:0] dato, input int ciclos, input int parar_at);
    int pre, k, wraps, lat, j;
    int enb_cyc = 0, load_cyc = 0, cnt_cyc = 0, bad_modo = 0, bad_d = 0;
    bit aborta, seen, nat;
    logic [15:0] q_exp;
    int unsigned acc;

    wraps = 0;
    if (m == MODO_CARGA) begin
      pre = 1; k = 0; aborta = 0; q_exp = dato;
    end else begin
      pre    = PRE;
      q_exp  = (PRE != 0) ? dato : ref_q;
      aborta = (parar_at > 0) && (parar_at < ciclos);
      k      = aborta ? parar_at : ciclos;
      for (int c = 0; c < k; c++) begin
        if (m == MODO_DESC) begin
          nat   = (q_exp == 16'd0);
          q_exp = q_exp - 16'd1;
        end else begin
          acc   = 32'(q_exp) + ((m == MODO_TRES) ? 32'd3 : 32'd1);
          nat   = acc > 32'hFFFF;
          q_exp = acc[15:0];
        end
        if (nat || rco_force) wraps++;
      end
      if (wraps > 255) wraps = 255;
    end
    lat   = pre + k + 1;
    ref_q = q_exp;

    wait_ready();
    bus.cmd_valid  = 1'b1;
    bus.cmd_modo   = m;
    bus.cmd_dato   = dato;
    bus.cmd_ciclos = ciclos[15:0];
    @(negedge clk);
    bus.cmd_valid = 1'b0;

    j = 0;
    seen = 0;
    while (!seen && j < 2000) begin
      bus.parar = 1'b0;
      if (enb) begin
        enb_cyc++;
        if (modo == MODO_CARGA) begin
          load_cyc++;
          if (D !== dato) bad_d++;
        end else begin
          cnt_cyc++;
          if (modo !== m) bad_modo++;
          if (cnt_cyc == parar_at) bus.parar = 1'b1;
        end
      end else if (parar_at < 0) bus.parar = 1'b1;
      if (parar_at < 0 && enb && modo == MODO_CARGA) bus.parar = 1'b1;
      if (bus.hecho) begin
        seen = 1;
        check("latency", j, lat);
        check("abortado", bus.abortado, aborta);
        check("q_final", bus.q_final, q_exp);
        check("vueltas", bus.vueltas, wraps);
      end else begin
        @(negedge clk);
        j++;
      end
    end
    bus.parar = 1'b0;
    check("hecho_seen", seen, 1);
    check("enb_cycles", enb_cyc, pre + k);
    check("load_cycles", load_cyc, pre);
    check("count_cycles", cnt_cyc, k);
    check("modo_bad", bad_modo, 0);
    check("D_bad", bad_d, 0);
    @(negedge clk);
    check("hecho_pulse", bus.hecho, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, guard, hecho_seen, enb_seen, sel, ci, pa;
    logic [1:0]  m;
    logic [15:0] dt;

    reset          = 1'b1;
    rco_force      = 1'b0;
    ref_q          = 16'd0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_modo   = 2'b00;
    bus.cmd_dato   = '0;
    bus.cmd_ciclos = '0;
    bus.parar      = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_enb", enb, 0);
    check("rst_modo", modo, 0);
    check("rst_D", D, 0);
    check("rst_hecho", bus.hecho, 0);
    check("rst_q_final", bus.q_final, 0);
    check("rst_vueltas", bus.vueltas, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1);

    // Directed scenarios, including the boundary cases.
    run_cmd(MODO_CARGA, 16'h00FF, 0, 0);
    run_cmd(MODO_CARGA, 16'hFFFE, 7, 0);
    run_cmd(MODO_ASC,   16'hFFFE, 5, 0);
    run_cmd(MODO_DESC,  16'h1234, 0, 0);
    run_cmd(MODO_CARGA, 16'h0100, 0, 0);
    run_cmd(MODO_TRES,  16'h0100, 100, 10);
    run_cmd(MODO_ASC,   16'h1000, 4, 0);
    run_cmd(MODO_ASC,   16'h1000, 3, 3);
    run_cmd(MODO_DESC,  16'h0002, 6, -1);
    rco_force = 1'b1;
    run_cmd(MODO_TRES,  16'h0000, 300, 0);
    rco_force = 1'b0;

    for (int n = 0; n < 30; n++) begin
      m   = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 2);
      dt  = (sel == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) :
            (sel == 1) ? 16'($urandom_range(0, 8)) : 16'($urandom);
      ci  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      sel = $urandom_range(0, 4);
      pa  = (sel == 1) ? $urandom_range(1, ci + 2) : (sel == 2) ? -1 : 0;
      run_cmd(m, dt, ci, pa);
    end

    // Asynchronous reset in the middle of a 20-cycle count.
    wait_ready();
    bus.cmd_valid  = 1'b1;
    bus.cmd_modo   = MODO_ASC;
    bus.cmd_dato   = 16'h0000;
    bus.cmd_ciclos = 16'd20;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cnt = 0;
    guard = 0;
    while (cnt < 5 && guard < 100) begin
      if (enb && modo != MODO_CARGA) cnt++;
      if (cnt < 5) @(negedge clk);
      guard++;
    end
    check("rst_mid_cnt", cnt, 5);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_enb", enb, 0);
    check("rst_mid_modo", modo, 0);
    check("rst_mid_D", D, 0);
    check("rst_mid_hecho", bus.hecho, 0);
    check("rst_mid_abortado", bus.abortado, 0);
    check("rst_mid_q_final", bus.q_final, 0);
    check("rst_mid_vueltas", bus.vueltas, 0);
    @(negedge clk);
    reset = 1'b0;
    ref_q = 16'd0;
    @(negedge clk);
    check("rst_mid_ready", bus.cmd_ready, 1);
    hecho_seen = 0;
    enb_seen   = 0;
    repeat (25) begin
      if (bus.hecho) hecho_seen++;
      if (enb) enb_seen++;
      @(negedge clk);
    end
    check("rst_mid_no_hecho", hecho_seen, 0);
    check("rst_mid_no_enb", enb_seen, 0);
    run_cmd(MODO_ASC, 16'h0042, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
